// File: rtl/toggle_pulse_conditioner_pkg.sv
// Shared types and defaults for the push-button input conditioning blocks.
// State encoding and default timing constants used by sibling conditioners.
package toggle_pulse_conditioner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } tpc_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_SYNC_STAGES     = 2;

endpackage

// File: rtl/toggle_pulse_conditioner_sync_chain.sv
// Parameterized-depth single-bit synchronizer with async active-low reset.
// The last flop of the chain is the synchronized output.
module sync_chain
  import toggle_pulse_conditioner_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else begin
      r_q <= {r_q[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_q[STAGES-1];

endmodule

// File: rtl/toggle_pulse_conditioner.sv
// Synchronizes and debounces a raw push-button, emitting one T-enable
// pulse per accepted press plus a debounced level and a wrapping count.
module toggle_pulse_conditioner
  import toggle_pulse_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       t_pulse,
  output logic       btn_level,
  output logic [7:0] press_count
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  tpc_state_e       r_state;
  tpc_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_pulse;
  logic             w_pulse_nxt;
  logic             r_level;
  logic             w_level_nxt;
  logic [7:0]       r_count;
  logic [7:0]       w_count_nxt;
  logic             w_btn_sync;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst),
    .i_d   (btn_in),
    .o_q   (w_btn_sync)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pulse_nxt = 1'b0;
    w_count_nxt = r_count;
    unique case (r_state)
      ST_IDLE: begin
        if (w_btn_sync) begin
          w_state_nxt = ST_PRESS_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!w_btn_sync) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = ST_PRESSED;
          w_pulse_nxt = 1'b1;
          w_count_nxt = r_count + 8'd1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_PRESSED: begin
        if (!w_btn_sync) begin
          w_state_nxt = ST_RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (w_btn_sync) begin
          w_state_nxt = ST_PRESSED;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    // level follows the state being entered so it stays aligned with it
    w_level_nxt = (w_state_nxt == ST_PRESSED) ||
                  (w_state_nxt == ST_RELEASE_WAIT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_pulse <= 1'b0;
      r_level <= 1'b0;
      r_count <= 8'd0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_pulse <= w_pulse_nxt;
      r_level <= w_level_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign t_pulse     = r_pulse;
  assign btn_level   = r_level;
  assign press_count = r_count;

endmodule

// File: doc/toggle_pulse_conditioner.md
Name: toggle_pulse_conditioner

Overview:
- Upstream stage of the toggle flip-flop: turns a raw, bouncy, asynchronous push-button into a clean single-cycle toggle-enable pulse.
- Its t_pulse output drives the flip-flop's T input directly.
- Synchronizes the input, debounces both press and release with a counter-based FSM, and keeps a wrapping press counter for debug.

Parameters:
- SYNC_STAGES, 2, synchronizer flop depth (legal values >=2).
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a press or a release (legal values >=2).
- CNT_W, $clog2(DEBOUNCE_CYCLES), debounce counter width (localparam, not overridable).

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0, released synchronously to clk externally).
- btn_in  input  1  raw asynchronous button level; 1 = pressed.
- t_pulse  output  1  one-cycle pulse per accepted press; connects to the flip-flop T input.
- btn_level  output  1  debounced button level.
- press_count  output  8  accepted-press count, wraps 255->0.

Behaviour:
- Reset (rst=0, async): synchronizer flops=0, state=IDLE, counter=0, t_pulse=0, btn_level=0, press_count=0. All outputs are registered.
- Synchronizer: SYNC_STAGES-deep shift of btn_in; btn_sync is the last stage. The FSM sees only btn_sync.
- FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
- IDLE: btn_sync=1 -> PRESS_WAIT, counter<=0.
- PRESS_WAIT:
  - btn_sync=0 -> IDLE (glitch rejected; no pulse).
  - Otherwise, counter==DEBOUNCE_CYCLES-1 -> PRESSED, t_pulse<=1, press_count<=press_count+1.
  - Otherwise counter<=counter+1.
- PRESSED: btn_sync=0 -> RELEASE_WAIT, counter<=0. Holding the button generates no further pulses.
- RELEASE_WAIT:
  - btn_sync=1 -> PRESSED (bounce on release; no pulse).
  - Otherwise, counter==DEBOUNCE_CYCLES-1 -> IDLE.
  - Otherwise counter<=counter+1.
- btn_level: registered; 1 exactly while the state is PRESSED or RELEASE_WAIT.
- t_pulse:
  - High for exactly one cycle per accepted press, never on two consecutive cycles.
  - Cleared the cycle after it is set.
- Latency: take edge 1 as the first clk edge sampling btn_in=1, with the input held stable. Then t_pulse and btn_level rise after edge SYNC_STAGES+DEBOUNCE_CYCLES+1 (edge 19 at defaults).
- Release latency: btn_level falls after edge SYNC_STAGES+DEBOUNCE_CYCLES+1, counted from the first edge sampling btn_in=0.
- Any input change shorter than DEBOUNCE_CYCLES cycles at btn_sync is ignored in both directions.
- Reset mid-operation:
  - Outputs clear immediately; any in-flight pulse is lost.
  - A button still held at reset release is re-detected as a new press after the full latency.
- press_count wrap: 255 + 1 press -> 0, with no flag.
- Counter never exceeds DEBOUNCE_CYCLES-1; it is don't-care in IDLE and PRESSED.

Decomposition:
- Shared package holds:
  - 2-bit state encoding: IDLE=0, PRESS_WAIT=1, PRESSED=2, RELEASE_WAIT=3.
  - Default DEBOUNCE_CYCLES and SYNC_STAGES constants, reused by sibling input-conditioning blocks.
- One sub-module: sync_chain (parameterized-depth, async active-low reset, 1-bit synchronizer), instantiated once.
- FSM, counter and output registers stay in the top module.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
- Clean press: btn_in 0->1 held 20 cycles -> t_pulse high for exactly one cycle after edge 7; btn_level=1 from edge 7; press_count=1.
- Press bounce: btn_in pulses 1 for 2 cycles, 0 for 1 cycle, repeated 3 times, then held 1 -> exactly one t_pulse, 7 edges after the final stable rise; press_count=1.
- Release bounce: from PRESSED, btn_in 0 for 2 cycles, 1 for 1 cycle, then 0 held -> no t_pulse; btn_level falls 7 edges after the final stable 0.
- Glitch: single-cycle btn_in=1 from IDLE -> t_pulse never asserts; btn_level stays 0; press_count unchanged.
- Wrap: 256 clean press/release sequences -> 256 single-cycle pulses; press_count ends at 0. A T flip-flop driven by t_pulse ends at 0.
- Async reset: rst=0 mid-cycle while in PRESS_WAIT with counter=2 -> all outputs 0 without waiting for a clk edge. After rst=1 with btn_in still 1 -> t_pulse after edge 7 of the new sequence.
